// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives datapath
// mux selects and write enables. Outputs are Moore (decoded from state)
// except the memready-qualified fetch enables and the zero-qualified pcen.
// Handshake: a memory access completes in the cycle memready = 1; FETCH,
// MEMRD and MEMWR hold their state and outputs until then.
module mips_mc_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       mr;
  logic       pcwrite;
  logic       branch;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;

  // With the handshake disabled every memory access completes in one cycle.
  assign mr    = MEM_HANDSHAKE ? memready : 1'b1;
  assign state = state_q;

  // State register; reset lands in FETCH and abandons any instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mr ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = mr ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = mr ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      RTYPEWB: state_d = FETCH;
      BEQEX:   state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JEX:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode; anything not set for a state stays 0.
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = mr;
        pcwrite   = mr;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite_s = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write enables are suppressed while reset is held.
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign irwrite  = irwrite_s & ~reset;
  assign regwrite = regwrite_s & ~reset;

endmodule
